reservation_station: RTL
========================

# reservation_station

Per-unit reservation station for the Tomasulo core, directly downstream of the decode control unit. It accepts one decoded instruction per cycle (ALU opcode plus operand values or producer tags), snoops the common data bus (CDB) for pending operands, and dispatches one ready entry per cycle to its functional unit. Its `full` output drives this unit's bit of the control unit's `isFull[2:0]` vector; one instance exists per ALU class (add/sub, multiply, divide).

## Interface
- `DEPTH`, 3: number of entries (2..8).
- `DATA_W`, 32: operand and CDB data width.
- `TAG_W`, 4: producer tag width; tag 0 means "no producer / value valid".
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: one clock; reset is asynchronous and active-low.
- `issue_valid` in 1: an instruction is presented for this unit.
- `issue_aluop` in 2: ALU opcode from the control unit.
- `issue_vj`, `issue_vk` in DATA_W: operand values, meaningful when the matching Q is 0.
- `issue_qj`, `issue_qk` in TAG_W: producer tags of the operands.
- `issue_tag` in TAG_W: destination tag of the instruction (nonzero).
- `full` out 1: all entries busy.
- `count` out $clog2(DEPTH+1): number of busy entries.
- `cdb_valid` in 1, `cdb_tag` in TAG_W, `cdb_data` in DATA_W: result broadcast.
- `exec_ready` in 1: functional unit accepts an operation this cycle.
- `exec_valid` out 1, `exec_aluop` out 2, `exec_a`/`exec_b` out DATA_W, `exec_tag` out TAG_W: dispatch.

## Operation
- Entry fields: busy, aluop, Vj, Qj, Vk, Qk, dest tag. An entry is ready when busy and Qj==0 and Qk==0 (registered values).
- Issue: accepted when `issue_valid && !full`; written into the lowest-index free entry. `issue_valid` while `full` is dropped; the upstream stalls on `full`.
- Issue-time bypass: if an issued Q equals `cdb_tag` with `cdb_valid` the same cycle, the entry stores `cdb_data` and Q=0.
- CDB snoop: every busy entry with Qj (Qk) == `cdb_tag`, nonzero, on `cdb_valid` captures `cdb_data` into Vj (Vk) and clears the Q. `cdb_valid` with tag 0 is ignored.
- Dispatch select: lowest-index ready entry (see Configuration). `exec_*` are combinational from registered state; `exec_valid` high iff any entry ready. Outputs other than `exec_valid` are 0 when it is low.
- Handshake: on `exec_valid && exec_ready` the selected entry's busy clears at the edge. `exec_valid` must not drop without handshake unless reset.
- Simultaneous issue and dispatch: both occur; free entries are determined from registered busy bits, so an entry freed this cycle is reusable next cycle only.
- `count` = popcount(busy); `full` = (count == DEPTH); both registered-state derived.

## Timing
- Reset: all busy, Q, V cleared; `full`=0, `count`=0, `exec_valid`=0, all `exec_*`=0. Reset mid-operation discards all entries immediately.
- Issue at edge T with ready operands (or bypassed from CDB at T): `exec_valid` high after T (cycle T+1). Minimum issue-to-dispatch latency 1 cycle.
- CDB broadcast at edge T completing last operand: entry dispatchable in cycle T+1.
- Dispatch handshake at edge T: `full` deasserts and `count` decrements in cycle T+1.
- Throughput: one issue and one dispatch per cycle sustained.

## Configuration
- `RS_OLDEST_FIRST_EN` defined: dispatch selects the oldest ready entry. A DEPTH×DEPTH age matrix is maintained: on issue into entry i, row i records which entries were busy at that edge; column i clears when entry i frees. Oldest ready = ready entry with no older ready entry.
- Not defined: lowest-index ready entry is dispatched; no age matrix is built.

## Test plan
- Reset with `rst_n`=0 mid-stream (2 busy entries) -> `count`=0, `full`=0, `exec_valid`=0 next observation, no dispatch of old entries after release.
- Issue aluop=2, Qj=Qk=0, Vj=5, Vk=3, tag=4, `exec_ready`=1 -> next cycle `exec_valid`=1, a=5, b=3, tag=4; entry freed the cycle after.
- Issue Qj=7 while CDB idle, then `cdb_valid` tag=7 data=0x1234 -> `exec_a`=0x1234 dispatched the cycle after the broadcast; issue with Qj=7 coincident with the broadcast -> bypassed, dispatch next cycle.
- Fill 3 entries with pending tags -> `full`=1, 4th `issue_valid` dropped (count stays 3); dispatch one with `exec_ready` -> `full`=0 next cycle, new issue accepted.
- Hold `exec_ready`=0 with ready entry -> `exec_valid` and payload stable for 5 cycles; raise `exec_ready` -> single dispatch.
- With `RS_OLDEST_FIRST_EN`: issue A into entry 1 then B into entry 0 (after entry 0 freed), both ready -> A dispatched first; without macro -> B first.

Source files
------------

// File: rtl/reservation_station.sv
`default_nettype none
// ============================================================================
// reservation_station : Tomasulo reservation station with CDB snoop/bypass,
//                       one issue and one dispatch per cycle.
// Option macro RS_OLDEST_FIRST_EN : dispatch oldest ready entry (age matrix);
//                                   default dispatches lowest-index ready entry.
// Revision : 1.0
// ============================================================================
module reservation_station #(
    parameter int DEPTH  = 3,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_valid,
    input  logic [1:0]        issue_aluop,
    input  logic [DATA_W-1:0] issue_vj,
    input  logic [DATA_W-1:0] issue_vk,
    input  logic [TAG_W-1:0]  issue_qj,
    input  logic [TAG_W-1:0]  issue_qk,
    input  logic [TAG_W-1:0]  issue_tag,
    output logic              full,
    output logic [CNT_W-1:0]  count,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic              exec_ready,
    output logic              exec_valid,
    output logic [1:0]        exec_aluop,
    output logic [DATA_W-1:0] exec_a,
    output logic [DATA_W-1:0] exec_b,
    output logic [TAG_W-1:0]  exec_tag
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [1:0]        aluop_q [DEPTH];
    logic [1:0]        aluop_d [DEPTH];
    logic [DATA_W-1:0] vj_q    [DEPTH];
    logic [DATA_W-1:0] vj_d    [DEPTH];
    logic [DATA_W-1:0] vk_q    [DEPTH];
    logic [DATA_W-1:0] vk_d    [DEPTH];
    logic [TAG_W-1:0]  qj_q    [DEPTH];
    logic [TAG_W-1:0]  qj_d    [DEPTH];
    logic [TAG_W-1:0]  qk_q    [DEPTH];
    logic [TAG_W-1:0]  qk_d    [DEPTH];
    logic [TAG_W-1:0]  tag_q   [DEPTH];
    logic [TAG_W-1:0]  tag_d   [DEPTH];

    logic [DEPTH-1:0]  ready;
    logic [IDX_W-1:0]  free_idx;
    logic [IDX_W-1:0]  sel_idx;
    logic              issue_acc;
    logic              disp;
    logic              cdb_hit;

`ifdef RS_OLDEST_FIRST_EN
    // older_q[i][j] set means entry j was already busy when entry i issued
    logic [DEPTH-1:0]  older_q [DEPTH];
    logic [DEPTH-1:0]  older_d [DEPTH];
`endif

    always_comb begin
        ready    = '0;
        count    = '0;
        free_idx = '0;
        sel_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ready[i] = busy_q[i] && (qj_q[i] == '0) && (qk_q[i] == '0);
            count    = count + CNT_W'(busy_q[i]);
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!busy_q[i]) free_idx = IDX_W'(i);
`ifdef RS_OLDEST_FIRST_EN
            if (ready[i] && ((older_q[i] & ready) == '0)) sel_idx = IDX_W'(i);
`else
            if (ready[i]) sel_idx = IDX_W'(i);
`endif
        end
        full       = (count == CNT_W'(DEPTH));
        exec_valid = |ready;
        exec_aluop = exec_valid ? aluop_q[sel_idx] : '0;
        exec_a     = exec_valid ? vj_q[sel_idx]    : '0;
        exec_b     = exec_valid ? vk_q[sel_idx]    : '0;
        exec_tag   = exec_valid ? tag_q[sel_idx]   : '0;
        issue_acc  = issue_valid && !full;
        disp       = exec_valid && exec_ready;
        cdb_hit    = cdb_valid && (cdb_tag != '0);
    end

    always_comb begin
        busy_d  = busy_q;
        aluop_d = aluop_q;
        vj_d    = vj_q;
        vk_d    = vk_q;
        qj_d    = qj_q;
        qk_d    = qk_q;
        tag_d   = tag_q;
`ifdef RS_OLDEST_FIRST_EN
        older_d = older_q;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            if (busy_q[i] && cdb_hit && (qj_q[i] == cdb_tag)) begin
                vj_d[i] = cdb_data;
                qj_d[i] = '0;
            end
            if (busy_q[i] && cdb_hit && (qk_q[i] == cdb_tag)) begin
                vk_d[i] = cdb_data;
                qk_d[i] = '0;
            end
            if (disp && (sel_idx == IDX_W'(i))) begin
                busy_d[i] = 1'b0;
            end
            // The issue slot comes from registered busy, so it never collides with dispatch
            if (issue_acc && (free_idx == IDX_W'(i))) begin
                busy_d[i]  = 1'b1;
                aluop_d[i] = issue_aluop;
                tag_d[i]   = issue_tag;
                if (cdb_hit && (issue_qj == cdb_tag)) begin
                    vj_d[i] = cdb_data;
                    qj_d[i] = '0;
                end else begin
                    vj_d[i] = issue_vj;
                    qj_d[i] = issue_qj;
                end
                if (cdb_hit && (issue_qk == cdb_tag)) begin
                    vk_d[i] = cdb_data;
                    qk_d[i] = '0;
                end else begin
                    vk_d[i] = issue_vk;
                    qk_d[i] = issue_qk;
                end
`ifdef RS_OLDEST_FIRST_EN
                older_d[i] = busy_q;
`endif
            end
        end
`ifdef RS_OLDEST_FIRST_EN
        if (disp) begin
            for (int r = 0; r < DEPTH; r++) begin
                older_d[r][sel_idx] = 1'b0;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                aluop_q[i] <= '0;
                vj_q[i]    <= '0;
                vk_q[i]    <= '0;
                qj_q[i]    <= '0;
                qk_q[i]    <= '0;
                tag_q[i]   <= '0;
`ifdef RS_OLDEST_FIRST_EN
                older_q[i] <= '0;
`endif
            end
        end else begin
            busy_q  <= busy_d;
            aluop_q <= aluop_d;
            vj_q    <= vj_d;
            vk_q    <= vk_d;
            qj_q    <= qj_d;
            qk_q    <= qk_d;
            tag_q   <= tag_d;
`ifdef RS_OLDEST_FIRST_EN
            older_q <= older_d;
`endif
        end
    end

endmodule
`default_nettype wire
